// File: rtl/sfft_pkg.sv
// ============================================================================
// Package  : sfft_pkg
// Brief    : Shared constants and types for the second-FFT request scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfft_pkg;

  localparam int N_CH   = 128;
  localparam int IDX_W  = $clog2(N_CH);
  localparam int N_SAMP = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic             msb;
    logic [IDX_W-1:0] index;
  } sched_req_t;

endpackage

`default_nettype wire

// File: rtl/sfft_scheduler_if.sv
// ============================================================================
// Interface : sfft_scheduler_if
// Brief     : Request, transfer and status signals of the scheduler.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sfft_scheduler_if #(
  parameter int PEND_W = 5
);
  import sfft_pkg::*;

  logic              assert_in;
  logic              assert_msb_in;
  logic [IDX_W-1:0]  assert_index_in;
  logic              fft_ready;
  logic              xfer_data_valid;
  logic              assert_out;
  logic              assert_msb_out;
  logic [IDX_W-1:0]  assert_index_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic [15:0]       drop_count;
  logic              timeout_err;

  modport master (
    output assert_in, assert_msb_in, assert_index_in, fft_ready, xfer_data_valid,
    input  assert_out, assert_msb_out, assert_index_out, busy, pending,
           overflow, drop_count, timeout_err
  );

  modport slave (
    input  assert_in, assert_msb_in, assert_index_in, fft_ready, xfer_data_valid,
    output assert_out, assert_msb_out, assert_index_out, busy, pending,
           overflow, drop_count, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/sched_fifo.sv
// ============================================================================
// Module   : sched_fifo
// Brief    : Synchronous first-word-fall-through FIFO of scheduler requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_fifo
  import sfft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  sched_req_t       i_wr_data,
  input  logic             i_pop,
  output sched_req_t       o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  sched_req_t       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sfft_scheduler.sv
// ============================================================================
// Module   : sfft_scheduler
// Brief    : Queues channel buffer-ready pulses and releases them one at a
//            time to data_transfer when second_fft is ready.
// Config   : SFFT_SCHED_DEDUP_EN - discard pushes already queued ({msb,index})
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfft_scheduler
  import sfft_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  sfft_scheduler_if.slave bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = $clog2(N_SAMP + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  sched_req_t        w_push_req;
  sched_req_t        w_head;
  sched_req_t        r_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_dup;
  logic              w_drop;
  logic              w_abort;
  logic [CNT_W-1:0]  w_count;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic              r_assert_out;
  logic              r_msb_out;
  logic [IDX_W-1:0]  r_index_out;
  logic              r_busy;
  logic              r_overflow;
  logic [15:0]       r_drop_count;
  logic              r_timeout_err;

  assign w_push_req = {bus.assert_msb_in, bus.assert_index_in};
  assign w_pop      = (r_state == IDLE) && !w_empty && bus.fft_ready;
  assign w_push     = bus.assert_in && !w_dup;
  assign w_drop     = w_push && w_full && !w_pop;

  sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (w_push_req),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

`ifdef SFFT_SCHED_DEDUP_EN
  logic [2*N_CH-1:0] r_pend_map;
  logic              w_push_ok;

  // The key leaving this cycle does not block its own re-queue.
  assign w_dup     = r_pend_map[w_push_req] && !(w_pop && (w_head == w_push_req));
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_map <= '0;
    end else begin
      if (w_pop)     r_pend_map[w_head]     <= 1'b0;
      if (w_push_ok) r_pend_map[w_push_req] <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_idle_nxt  = r_idle_cnt;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_state_nxt = WAIT;
        w_beat_nxt  = '0;
        w_idle_nxt  = '0;
      end
      WAIT: begin
        if (bus.xfer_data_valid) begin
          w_idle_nxt = '0;
          w_beat_nxt = r_beat_cnt + 1'b1;
          if (r_beat_cnt == BEAT_W'(N_SAMP - 1)) w_state_nxt = GAP;
        end else if (r_idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_req         <= '0;
      r_assert_out  <= 1'b0;
      r_msb_out     <= 1'b0;
      r_index_out   <= '0;
      r_busy        <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_beat_cnt   <= w_beat_nxt;
      r_idle_cnt   <= w_idle_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_assert_out <= (r_state == ISSUE);
      if (w_pop) r_req <= w_head;
      if (r_state == ISSUE) begin
        r_msb_out   <= r_req.msb;
        r_index_out <= r_req.index;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
      end
      if (w_abort) r_timeout_err <= 1'b1;
    end
  end

  assign bus.assert_out       = r_assert_out;
  assign bus.assert_msb_out   = r_msb_out;
  assign bus.assert_index_out = r_index_out;
  assign bus.busy             = r_busy;
  assign bus.pending          = w_count;
  assign bus.overflow         = r_overflow;
  assign bus.drop_count       = r_drop_count;
  assign bus.timeout_err      = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_sfft_scheduler.sv
// ============================================================================
// Module   : tb_sfft_scheduler
// Brief    : Directed self-checking bench for sfft_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfft_scheduler;
  import sfft_pkg::*;

`ifdef SFFT_SCHED_DEDUP_EN
  localparam int EXP_DUP_PEND = 1;
`else
  localparam int EXP_DUP_PEND = 2;
`endif

  typedef struct {
    logic       a_in;
    logic       msb;
    logic [6:0] idx;
    logic       rdy;
    logic       xv;
    logic       e_aout;
    logic       e_msb;
    logic [6:0] e_idx;
    logic       e_busy;
    logic [4:0] e_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   exp_idx [20];
  vec_t vt [21];

  sfft_scheduler_if bus ();

  sfft_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic a, logic m, logic [6:0] ix, logic r, logic xv,
                              logic ea, logic em, logic [6:0] ei, logic eb, logic [4:0] ep);
    vec_t v;
    v.a_in = a;  v.msb = m;    v.idx = ix;   v.rdy = r;     v.xv = xv;
    v.e_aout = ea; v.e_msb = em; v.e_idx = ei; v.e_busy = eb; v.e_pend = ep;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_assert_out"}, bus.assert_out, 0);
    check({tag, "_msb_out"}, bus.assert_msb_out, 0);
    check({tag, "_index_out"}, bus.assert_index_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_pending"}, bus.pending, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_drop_count"}, bus.drop_count, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  task automatic push(input logic m, input int ix);
    bus.assert_in       = 1'b1;
    bus.assert_msb_in   = m;
    bus.assert_index_in = 7'(ix);
    step();
    bus.assert_in = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.assert_out && cyc < budget);
    check({tag, "_pulse_seen"}, bus.assert_out, 1);
  endtask

  // Collects n issues, checking order against exp_idx and pulse spacing.
  task automatic collect(input string tag, input int n, input int budget, input logic exp_msb);
    int got = 0;
    int cyc = 0;
    int last = 0;
    while (got < n && cyc < budget) begin
      step();
      cyc++;
      if (bus.assert_out) begin
        check({tag, "_index"}, bus.assert_index_out, exp_idx[got]);
        check({tag, "_msb"}, bus.assert_msb_out, exp_msb);
        if (got > 0) check({tag, "_spacing_ge_19"}, ((cyc - last) >= N_SAMP + 3) ? 1 : 0, 1);
        last = cyc;
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    int pulses;

    bus.assert_in       = 1'b0;
    bus.assert_msb_in   = 1'b0;
    bus.assert_index_in = '0;
    bus.fft_ready       = 1'b0;
    bus.xfer_data_valid = 1'b0;
    rst = 1'b1;

    // Single request: push, ISSUE, 16 beats (the beat during ISSUE is ignored), GAP.
    vt[0] = mk(1, 1, 5, 1, 0,  0, 0, 0, 0, 1);
    vt[1] = mk(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
    vt[2] = mk(0, 0, 0, 1, 1,  1, 1, 5, 1, 0);
    for (int i = 3; i <= 18; i++) vt[i] = mk(0, 0, 0, 1, 1,  0, 1, 5, 1, 0);
    vt[19] = mk(0, 0, 0, 1, 0,  0, 1, 5, 0, 0);
    vt[20] = mk(0, 0, 0, 1, 0,  0, 1, 5, 0, 0);

    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 21; i++) begin
      bus.assert_in       = vt[i].a_in;
      bus.assert_msb_in   = vt[i].msb;
      bus.assert_index_in = vt[i].idx;
      bus.fft_ready       = vt[i].rdy;
      bus.xfer_data_valid = vt[i].xv;
      step();
      check($sformatf("vec%0d_assert_out", i), bus.assert_out, vt[i].e_aout);
      check($sformatf("vec%0d_msb_out", i), bus.assert_msb_out, vt[i].e_msb);
      check($sformatf("vec%0d_index_out", i), bus.assert_index_out, vt[i].e_idx);
      check($sformatf("vec%0d_busy", i), bus.busy, vt[i].e_busy);
      check($sformatf("vec%0d_pending", i), bus.pending, vt[i].e_pend);
    end

    // Burst of 20 with fft_ready low: 16 accepted, 4 dropped.
    bus.fft_ready = 1'b0;
    bus.xfer_data_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.assert_in       = 1'b1;
      bus.assert_msb_in   = 1'b0;
      bus.assert_index_in = 7'(i);
      step();
      if (i == 15) begin
        check("burst_full_pending", bus.pending, 16);
        check("burst_full_no_overflow", bus.overflow, 0);
      end
      if (i == 16) begin
        check("burst_first_drop_overflow", bus.overflow, 1);
        check("burst_first_drop_count", bus.drop_count, 1);
      end
    end
    check("burst_pending", bus.pending, 16);
    check("burst_drop_count", bus.drop_count, 4);

    // Push into a full FIFO on the pop cycle is accepted.
    bus.assert_index_in = 7'd100;
    bus.fft_ready       = 1'b1;
    step();
    bus.assert_in = 1'b0;
    check("full_push_pop_pending", bus.pending, 16);
    check("full_push_pop_drops", bus.drop_count, 4);

    for (int i = 0; i < 16; i++) exp_idx[i] = i;
    exp_idx[16] = 100;
    bus.xfer_data_valid = 1'b1;
    collect("burst_issue", 17, 17 * 19 + 40, 1'b0);
    repeat (20) step();
    bus.xfer_data_valid = 1'b0;
    step();
    check("burst_done_busy", bus.busy, 0);
    check("burst_done_pending", bus.pending, 0);

    // Backpressure: nothing issues while fft_ready is low.
    bus.fft_ready = 1'b0;
    push(1'b1, 30);
    push(1'b1, 31);
    push(1'b1, 32);
    pulses = 0;
    repeat (10) begin
      step();
      if (bus.assert_out) pulses++;
    end
    check("bp_no_issue", pulses, 0);
    check("bp_pending", bus.pending, 3);
    check("bp_busy", bus.busy, 0);
    exp_idx[0] = 30;
    exp_idx[1] = 31;
    exp_idx[2] = 32;
    bus.fft_ready = 1'b1;
    bus.xfer_data_valid = 1'b1;
    collect("bp_issue", 3, 100, 1'b1);
    repeat (20) step();
    bus.xfer_data_valid = 1'b0;
    step();
    check("bp_done_busy", bus.busy, 0);

    // Timeout: 4 beats then silence.
    push(1'b0, 9);
    wait_pulse("to_first", 10);
    check("to_first_index", bus.assert_index_out, 9);
    bus.xfer_data_valid = 1'b1;
    repeat (4) step();
    bus.xfer_data_valid = 1'b0;
    repeat (250) step();
    check("to_not_yet", bus.timeout_err, 0);
    check("to_still_busy", bus.busy, 1);
    repeat (10) step();
    check("to_err_set", bus.timeout_err, 1);
    check("to_back_idle", bus.busy, 0);
    push(1'b0, 11);
    wait_pulse("to_next", 10);
    check("to_next_index", bus.assert_index_out, 11);
    check("to_err_sticky", bus.timeout_err, 1);
    bus.xfer_data_valid = 1'b1;
    repeat (20) step();
    bus.xfer_data_valid = 1'b0;
    step();
    check("to_next_done", bus.busy, 0);

    // Duplicate request while queued.
    bus.fft_ready = 1'b0;
    push(1'b0, 7);
    push(1'b0, 7);
    step();
    check("dup_pending", bus.pending, EXP_DUP_PEND);
    check("dup_no_drop", bus.drop_count, 4);

    // Reset in the middle of WAIT discards everything.
    bus.fft_ready = 1'b1;
    wait_pulse("rst_issue", 10);
    check("rst_issue_index", bus.assert_index_out, 7);
    bus.xfer_data_valid = 1'b1;
    repeat (8) step();
    rst = 1'b1;
    step();
    check_reset_outputs("midwait_reset");
    rst = 1'b0;
    bus.xfer_data_valid = 1'b0;
    pulses = 0;
    repeat (60) begin
      step();
      if (bus.assert_out) pulses++;
    end
    check("post_reset_no_issue", pulses, 0);
    check("post_reset_pending", bus.pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sfft_scheduler.md
# sfft_scheduler

Request scheduler between `data_store` and `data_transfer` in the second-FFT chain. It captures per-channel buffer-ready pulses (`assert`, `assert_msb`, `assert_index`) from `data_store` into a request FIFO. It releases them to `data_transfer` one at a time, only when `second_fft` reports ready and the previous transfer has delivered all its samples. This prevents back-to-back channel asserts from overrunning the single transfer/FFT path.

## Interface
Parameters:
- `N_CH`, 128, number of channels; index width is `$clog2(N_CH)` = 7
- `FIFO_DEPTH`, 16, request FIFO entries (power of two)
- `N_SAMP`, 16, `data_valid` beats per transfer
- `TIMEOUT`, 255, max idle cycles between beats in WAIT before abort

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `assert_in`  in  1  one-cycle pulse from `data_store`: channel buffer half full
- `assert_msb_in`  in  1  buffer half that is ready
- `assert_index_in`  in  7  channel of the pulse
- `fft_ready`  in  1  `second_fft` ready
- `xfer_data_valid`  in  1  `data_transfer` sample beat
- `assert_out`  out  1  one-cycle pulse to `data_transfer`
- `assert_msb_out`  out  1  half for issued request
- `assert_index_out`  out  7  channel for issued request
- `busy`  out  1  FSM not in IDLE
- `pending`  out  5  FIFO occupancy, 0..16
- `overflow`  out  1  sticky; a request was dropped on a full FIFO
- `drop_count`  out  16  dropped requests, saturating
- `timeout_err`  out  1  sticky; a WAIT aborted on timeout

## Operation
- Push: `assert_in` high pushes {msb, index}.
  - FIFO full with no pop in the same cycle: drop, set `overflow`, increment `drop_count` (saturates at 0xFFFF).
  - FIFO full with a pop in the same cycle: accept the push.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE → ISSUE when FIFO is non-empty and `fft_ready`=1. The request is popped on this transition.
  - ISSUE (1 cycle): `assert_out`=1 with the popped msb/index registered onto the outputs. Then → WAIT with the beat counter at 0.
  - WAIT: each `xfer_data_valid` increments the beat counter and clears the idle counter. On beat N_SAMP → GAP.
  - WAIT abort: if the idle counter reaches TIMEOUT, set `timeout_err` and → IDLE.
  - GAP (1 cycle) → IDLE. This guarantees at least 1 dead cycle between transfers.
- `xfer_data_valid` outside WAIT is ignored.
- `fft_ready` is sampled only in IDLE. Deassertion during WAIT does not affect the transfer in flight.
- `assert_msb_out` and `assert_index_out` hold their last issued values when `assert_out`=0.
- `pending` counts push/pop with 5-bit width. A simultaneous push and pop leaves it unchanged.

## Timing
- Reset values: `assert_out`=0, `assert_msb_out`=0, `assert_index_out`=0, `busy`=0, `pending`=0, `overflow`=0, `drop_count`=0, `timeout_err`=0. The FIFO is emptied and the FSM enters IDLE.
- Reset asserted mid-transfer: outputs take their reset values on the next edge, and the in-flight request is discarded.
- Latency with FIFO empty, FSM in IDLE, `fft_ready`=1: `assert_in` sampled at edge t puts `assert_out` high for the cycle after edge t+2.
- Minimum spacing between consecutive `assert_out` pulses: N_SAMP + 3 cycles (ISSUE + N_SAMP beats + GAP + IDLE).
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `SFFT_SCHED_DEDUP_EN` defined:
  - An N_CH×2 pending bitmap, indexed by {msb, index}, marks queued requests.
  - A push whose bit is already set is discarded silently. It does not count as overflow.
  - The bit is cleared on pop.
  - A same-cycle push and pop of the same key: the push is accepted and the bit stays set.
- `SFFT_SCHED_DEDUP_EN` undefined: no bitmap; every `assert_in` is queued subject to capacity.

## Structure
- Shared package `sfft_pkg`:
  - constants `N_CH`, `IDX_W`, `N_SAMP`
  - state enum `sched_state_t` {IDLE, ISSUE, WAIT, GAP}
  - request struct `sched_req_t` {msb, index}
- One sub-module, `sched_fifo`: synchronous FIFO of `sched_req_t`, FIFO_DEPTH deep, with full/empty/count outputs and first-word-fall-through read.
- The FSM, counters and dedup bitmap live in `sfft_scheduler`.

## Test plan
- Single request: `fft_ready`=1, pulse `assert_in` (index 5, msb 1), drive 16 beats → one `assert_out` with index 5, msb 1, 2 cycles after input; `busy` falls after GAP.
- Burst: 20 consecutive pulses for indices 0..19 with no pops → first 16 (or 17 if the first pop coincides) accepted, `overflow`=1, `drop_count` = 20 − accepted, issue order preserved.
- Backpressure: `fft_ready`=0 with 3 queued → no `assert_out`, `pending`=3; raise `fft_ready` → 3 issues, each spaced ≥ 19 cycles.
- Timeout: issue a request, supply 4 beats then none → `timeout_err`=1 after 255 idle cycles, FSM returns to IDLE, next request issues.
- Dedup: with `SFFT_SCHED_DEDUP_EN`, pulse index 7/msb 0 twice while queued → `pending`=1, `drop_count`=0; without the macro → `pending`=2.
- Reset mid-WAIT: assert `rst` after 8 beats → all outputs at reset values next cycle; previously queued requests are not issued.
